uart_tx_fifo_param: RTL and testbench
=====================================

// Module: uart_tx_fifo_param
// PURPOSE
//  Parametrised UART transmitter: configurable data width, parity, stop bits and baud divisor,
//  fronted by a small TX FIFO so the host can queue bytes with a ready/enable handshake.
//  Frames are sent back-to-back with no idle gap while the FIFO holds data.
//  Used as the serial debug/console output of the processor SoC.
// PARAMETERS
//  CLKS_PER_BIT  16  Clk cycles per serial bit (>=2)
//  DATA_BITS     8   data bits per frame (5..9), sent LSB first
//  PARITY        0   0 = none, 1 = odd, 2 = even
//  STOP_BITS     1   1 or 2 stop bits
//  FIFO_DEPTH    4   TX FIFO entries (power of 2, >=2)
// PORTS
//  Clk        in   1                        system clock, rising edge
//  Rst        in   1                        synchronous reset, active high
//  TxData     in   DATA_BITS                word to queue
//  TxEn       in   1                        push strobe; accepted when TxEn && TxReady
//  TxReady    out  1                        FIFO not full
//  Tx         out  1                        serial line, idle high
//  TxDone     out  1                        1-cycle pulse after last stop bit of each frame
//  TxBusy     out  1                        frame in progress (state != IDLE)
//  FifoCount  out  $clog2(FIFO_DEPTH)+1     queued words (excludes the word on the line)
// BEHAVIOUR
//  Reset (sync, Rst=1 at rising Clk): Tx=1, TxDone=0, TxBusy=0, FifoCount=0, TxReady=1,
//   FSM=IDLE, bit/baud counters=0. Reset mid-frame aborts: Tx=1 next edge, FIFO flushed,
//   no TxDone.
//  FIFO: push when TxEn && TxReady; TxReady = !full (registered count). Push while full is
//   dropped, with no overwrite and no error flag. Push and pop in the same cycle: both happen, count
//   unchanged. Read/write pointers wrap modulo FIFO_DEPTH.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> (START | IDLE).
//   IDLE: when FifoCount!=0, pop into shift reg, go START; Tx low from the next edge.
//   START: Tx=0 for CLKS_PER_BIT cycles.
//   DATA: Tx=shift[0], shift right every CLKS_PER_BIT cycles, DATA_BITS bits.
//   PARITY (only if PARITY!=0): parity bit held CLKS_PER_BIT cycles; odd => total ones in
//    data+parity is odd; even => even. Parity is computed from the popped word.
//   STOP: Tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle: TxDone=1 next edge
//    (exactly 1 cycle); if FIFO non-empty, pop in that cycle and enter START directly (no
//    idle bit), else IDLE.
//  Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
//  TxData is sampled only at push; later changes never affect queued/in-flight words.
//  TxEn is level-qualified: held high for N cycles with TxReady=1 pushes N words.
//  All outputs registered; Tx glitch-free.
// TESTING (CLKS_PER_BIT=4 unless noted)
//  1. Reset, push 0x15 (8N1) -> Tx bits 0,1,0,1,0,1,0,0,0,1, each 4 cycles; TxDone pulses once
//     40 cycles after pop; Tx stays 1 afterwards, TxBusy=0.
//  2. 8E1 push 0x07 -> parity bit 1; 8O1 push 0x07 -> parity bit 0; frame length 44 cycles.
//  3. FIFO_DEPTH=4, idle, TxEn=1 for 6 cycles with 0x15,0x05,0x06,0x08,0x09,0x0A -> first popped
//     at once, next 4 queued, 0x0A dropped (TxReady=0 that cycle); exactly 5 frames back-to-back,
//     5 TxDone pulses, stop bit of each frame immediately followed by a start bit.
//  4. Rst=1 for 1 cycle during data bit 3 with 2 words queued -> next edge Tx=1, FifoCount=0,
//     TxBusy=0, no TxDone; a subsequent push of 0x06 transmits a clean frame.
//  5. DATA_BITS=7, STOP_BITS=2, PARITY=0, push 0x7F -> start, 7 ones, 2 stop bits = 40 cycles;
//     TxDone after cycle 40.
//  6. Push and pop in the same cycle with FifoCount=2 -> FifoCount stays 2; the FIFO pointers wrap
//     correctly across 10 consecutive words, and the words are received in order.

Source files
------------

// File: rtl/uart_tx_fifo_param.sv
// ============================================================================
// Module   : uart_tx_fifo_param
// Function : UART transmitter with configurable data width, parity, stop bits
//            and baud divisor, fronted by a small TX FIFO with a ready/enable
//            push handshake. Queued words go out back-to-back with no idle bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_tx_fifo_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [DATA_BITS-1:0]          TxData,
  input  logic                          TxEn,
  output logic                          TxReady,
  output logic                          Tx,
  output logic                          TxDone,
  output logic                          TxBusy,
  output logic [$clog2(FIFO_DEPTH):0]   FifoCount
);

  localparam int c_ptrW   = $clog2(FIFO_DEPTH);
  localparam int c_countW = c_ptrW + 1;
  localparam int c_cntW   = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int c_bitW   = $clog2(DATA_BITS);

  localparam logic [c_cntW-1:0]   c_bitLast  = c_cntW'(CLKS_PER_BIT - 1);
  localparam logic [c_cntW-1:0]   c_stopLast = c_cntW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [c_bitW-1:0]   c_dataLast = c_bitW'(DATA_BITS - 1);
  localparam logic [c_countW-1:0] c_full     = c_countW'(FIFO_DEPTH);

  localparam logic [2:0] c_sIdle   = 3'd0;
  localparam logic [2:0] c_sStart  = 3'd1;
  localparam logic [2:0] c_sData   = 3'd2;
  localparam logic [2:0] c_sParity = 3'd3;
  localparam logic [2:0] c_sStop   = 3'd4;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptrW-1:0]    r_wrPtr;
  logic [c_ptrW-1:0]    r_rdPtr;
  logic [c_countW-1:0]  r_count;
  logic                 r_ready;

  // Transmit engine state
  logic [2:0]           r_state;
  logic [c_cntW-1:0]    r_baudCnt;
  logic [c_bitW-1:0]    r_bitCnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parBit;
  logic                 r_tx;
  logic                 r_done;
  logic                 r_busy;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_baudLast;
  logic                 w_stopEnd;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_headParity;
  logic [c_countW-1:0]  w_countNext;

  assign w_head     = r_mem[r_rdPtr];
  assign w_push     = TxEn && r_ready;
  assign w_baudLast = (r_baudCnt == c_bitLast);
  assign w_stopEnd  = (r_state == c_sStop) && (r_baudCnt == c_stopLast);
  // A word leaves the FIFO either from idle or at the very last stop cycle,
  // which is what makes consecutive frames abut without an idle bit.
  assign w_pop      = (r_count != '0) && ((r_state == c_sIdle) || w_stopEnd);

  // Parity of the word at the FIFO head, latched together with the pop
  generate
    if (PARITY == 1) begin : g_parOdd
      assign w_headParity = ~^w_head;
    end else if (PARITY == 2) begin : g_parEven
      assign w_headParity = ^w_head;
    end else begin : g_parNone
      assign w_headParity = 1'b0;
    end
  endgenerate

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel
  always_comb begin
    w_countNext = r_count;
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + c_countW'(1);
      2'b01:   w_countNext = r_count - c_countW'(1);
      default: w_countNext = r_count;
    endcase
  end

  // FIFO data array; stale contents are harmless because pointers reset
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= TxData;
    end
  end

  // FIFO pointers, count and registered not-full flag
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ready <= 1'b1;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + c_ptrW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + c_ptrW'(1);
      r_count <= w_countNext;
      r_ready <= (w_countNext != c_full);
    end
  end

  // Frame sequencer; Tx is registered and updated only on bit boundaries
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= c_sIdle;
      r_baudCnt <= '0;
      r_bitCnt  <= '0;
      r_shift   <= '0;
      r_parBit  <= 1'b0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_sIdle: begin
          if (w_pop) begin
            r_shift   <= w_head;
            r_parBit  <= w_headParity;
            r_baudCnt <= '0;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= c_sStart;
          end
        end
        c_sStart: begin
          if (w_baudLast) begin
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
            r_state   <= c_sData;
          end else begin
            r_baudCnt <= r_baudCnt + c_cntW'(1);
          end
        end
        c_sData: begin
          if (w_baudLast) begin
            r_baudCnt <= '0;
            if (r_bitCnt == c_dataLast) begin
              if (PARITY != 0) begin
                r_tx    <= r_parBit;
                r_state <= c_sParity;
              end else begin
                r_tx    <= 1'b1;
                r_state <= c_sStop;
              end
            end else begin
              r_bitCnt <= r_bitCnt + c_bitW'(1);
              r_tx     <= r_shift[0];
              r_shift  <= {1'b0, r_shift[DATA_BITS-1:1]};
            end
          end else begin
            r_baudCnt <= r_baudCnt + c_cntW'(1);
          end
        end
        c_sParity: begin
          if (w_baudLast) begin
            r_baudCnt <= '0;
            r_tx      <= 1'b1;
            r_state   <= c_sStop;
          end else begin
            r_baudCnt <= r_baudCnt + c_cntW'(1);
          end
        end
        c_sStop: begin
          if (w_stopEnd) begin
            r_baudCnt <= '0;
            r_done    <= 1'b1;
            if (w_pop) begin
              r_shift  <= w_head;
              r_parBit <= w_headParity;
              r_tx     <= 1'b0;
              r_state  <= c_sStart;
            end else begin
              r_tx     <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= c_sIdle;
            end
          end else begin
            r_baudCnt <= r_baudCnt + c_cntW'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= c_sIdle;
        end
      endcase
    end
  end

  assign TxReady   = r_ready;
  assign Tx        = r_tx;
  assign TxDone    = r_done;
  assign TxBusy    = r_busy;
  assign FifoCount = r_count;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo_param.sv
// ============================================================================
// Module   : tb_uart_tx_fifo_param
// Function : Directed self-checking bench for uart_tx_fifo_param. Four
//            instances: 8N1, 8E1, 8O1 and 7N2, all CLKS_PER_BIT=4, depth 4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_fifo_param;

  logic       Clk = 1'b0;
  logic [3:0] rst = 4'h0;
  logic [3:0] en  = 4'h0;
  logic [3:0] rdy;
  logic [3:0] tx;
  logic [3:0] done;
  logic [3:0] busy;
  logic [7:0] din [3];
  logic [6:0] din7 = 7'h0;
  logic [2:0] cnt [4];

  int nChecks = 0;
  int nFails  = 0;

  always #5 Clk = ~Clk;

  uart_tx_fifo_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_n1 (
    .Clk(Clk), .Rst(rst[0]), .TxData(din[0]), .TxEn(en[0]), .TxReady(rdy[0]),
    .Tx(tx[0]), .TxDone(done[0]), .TxBusy(busy[0]), .FifoCount(cnt[0]));

  uart_tx_fifo_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e1 (
    .Clk(Clk), .Rst(rst[1]), .TxData(din[1]), .TxEn(en[1]), .TxReady(rdy[1]),
    .Tx(tx[1]), .TxDone(done[1]), .TxBusy(busy[1]), .FifoCount(cnt[1]));

  uart_tx_fifo_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o1 (
    .Clk(Clk), .Rst(rst[2]), .TxData(din[2]), .TxEn(en[2]), .TxReady(rdy[2]),
    .Tx(tx[2]), .TxDone(done[2]), .TxBusy(busy[2]), .FifoCount(cnt[2]));

  uart_tx_fifo_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_n2 (
    .Clk(Clk), .Rst(rst[3]), .TxData(din7), .TxEn(en[3]), .TxReady(rdy[3]),
    .Tx(tx[3]), .TxDone(done[3]), .TxBusy(busy[3]), .FifoCount(cnt[3]));

  // 8N1 line sequence, first transmitted bit in bit 0
  function automatic logic [15:0] frame8n1(input logic [7:0] v);
    return {6'b0, 1'b1, v, 1'b0};
  endfunction

  task automatic setData(input int d, input logic [7:0] v);
    if (d == 3) din7 = v[6:0];
    else        din[d] = v;
  endtask

  // Single push: returns #1 after the push edge
  task automatic pushOne(input int d, input logic [7:0] v);
    @(negedge Clk);
    setData(d, v);
    en[d] = 1'b1;
    @(posedge Clk);
    #1;
    en[d] = 1'b0;
    nChecks++;
    if (cnt[d] !== 3'd1) begin
      nFails++;
      $display("FAIL push_count dut%0d: got %0d expected 1", d, cnt[d]);
    end
  endtask

  // Checks every cycle of one frame, starting at the negedge after the pop edge
  task automatic expectFrame(input int d, input logic [15:0] bits, input int nbits,
                             input logic doneAtStart, input string name);
    for (int k = 0; k < nbits * 4; k++) begin
      @(negedge Clk);
      nChecks++;
      if (tx[d] !== bits[k/4]) begin
        nFails++;
        $display("FAIL %s tx cycle %0d: got %b expected %b", name, k, tx[d], bits[k/4]);
      end
      nChecks++;
      if (done[d] !== ((k == 0) ? doneAtStart : 1'b0)) begin
        nFails++;
        $display("FAIL %s txdone cycle %0d: got %b expected %b", name, k, done[d],
                 (k == 0) ? doneAtStart : 1'b0);
      end
      if (k == 0) begin
        nChecks++;
        if (busy[d] !== 1'b1) begin
          nFails++;
          $display("FAIL %s busy at start: got %b expected 1", name, busy[d]);
        end
      end
    end
  endtask

  // After the last frame: one TxDone pulse, line idle high, not busy
  task automatic expectEnd(input int d, input string name);
    @(negedge Clk);
    nChecks++;
    if (done[d] !== 1'b1 || tx[d] !== 1'b1 || busy[d] !== 1'b0) begin
      nFails++;
      $display("FAIL %s end: got done=%b tx=%b busy=%b expected done=1 tx=1 busy=0",
               name, done[d], tx[d], busy[d]);
    end
    @(negedge Clk);
    nChecks++;
    if (done[d] !== 1'b0 || tx[d] !== 1'b1) begin
      nFails++;
      $display("FAIL %s after end: got done=%b tx=%b expected done=0 tx=1", name, done[d], tx[d]);
    end
  endtask

  task automatic test_reset();
    rst = 4'hF;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    for (int d = 0; d < 4; d++) begin
      nChecks++;
      if (tx[d] !== 1'b1 || done[d] !== 1'b0 || busy[d] !== 1'b0 ||
          cnt[d] !== 3'd0 || rdy[d] !== 1'b1) begin
        nFails++;
        $display("FAIL reset dut%0d: got tx=%b done=%b busy=%b cnt=%0d rdy=%b expected 1 0 0 0 1",
                 d, tx[d], done[d], busy[d], cnt[d], rdy[d]);
      end
    end
    rst = 4'h0;
  endtask

  task automatic test_single_frame();
    pushOne(0, 8'h15);
    @(posedge Clk);
    expectFrame(0, 16'b0000_0010_0010_1010, 10, 1'b0, "8n1_0x15");
    expectEnd(0, "8n1_0x15");
  endtask

  task automatic test_parity();
    pushOne(1, 8'h07);
    @(posedge Clk);
    expectFrame(1, 16'b0000_0110_0000_1110, 11, 1'b0, "8e1_0x07");
    expectEnd(1, "8e1_0x07");
    pushOne(2, 8'h07);
    @(posedge Clk);
    expectFrame(2, 16'b0000_0100_0000_1110, 11, 1'b0, "8o1_0x07");
    expectEnd(2, "8o1_0x07");
  endtask

  task automatic test_seven_data_two_stop();
    pushOne(3, 8'h7F);
    @(posedge Clk);
    expectFrame(3, 16'b0000_0011_1111_1110, 10, 1'b0, "7n2_0x7f");
    expectEnd(3, "7n2_0x7f");
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [6];
    w = '{8'h15, 8'h05, 8'h06, 8'h08, 8'h09, 8'h0A};
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge Clk);
          din[0] = w[i];
          en[0]  = 1'b1;
          if (i == 5) begin
            nChecks++;
            if (rdy[0] !== 1'b0 || cnt[0] !== 3'd4) begin
              nFails++;
              $display("FAIL b2b full: got rdy=%b cnt=%0d expected rdy=0 cnt=4", rdy[0], cnt[0]);
            end
          end
          @(posedge Clk);
        end
        @(negedge Clk);
        en[0] = 1'b0;
        nChecks++;
        if (cnt[0] !== 3'd4) begin
          nFails++;
          $display("FAIL b2b drop: got cnt=%0d expected 4", cnt[0]);
        end
      end
      begin
        @(negedge Clk);
        @(posedge Clk);
        @(posedge Clk);
        for (int i = 0; i < 5; i++) begin
          expectFrame(0, frame8n1(w[i]), 10, (i != 0), $sformatf("b2b_frame%0d", i));
        end
        expectEnd(0, "b2b");
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    @(negedge Clk); din[0] = 8'h15; en[0] = 1'b1;
    @(posedge Clk);
    @(negedge Clk); din[0] = 8'h05;
    @(posedge Clk);
    @(negedge Clk); din[0] = 8'h06;
    @(posedge Clk);
    @(negedge Clk); en[0] = 1'b0;
    nChecks++;
    if (cnt[0] !== 3'd2) begin
      nFails++;
      $display("FAIL midrst queued: got cnt=%0d expected 2", cnt[0]);
    end
    // now at cycle 1 of the frame; data bit 3 occupies cycles 16..19
    repeat (15) @(negedge Clk);
    nChecks++;
    if (tx[0] !== 1'b0) begin
      nFails++;
      $display("FAIL midrst bit3: got tx=%b expected 0", tx[0]);
    end
    rst[0] = 1'b1;
    @(posedge Clk);
    #1;
    rst[0] = 1'b0;
    @(negedge Clk);
    nChecks++;
    if (tx[0] !== 1'b1 || cnt[0] !== 3'd0 || busy[0] !== 1'b0 || done[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      nFails++;
      $display("FAIL midrst abort: got tx=%b cnt=%0d busy=%b done=%b rdy=%b expected 1 0 0 0 1",
               tx[0], cnt[0], busy[0], done[0], rdy[0]);
    end
    for (int k = 0; k < 50; k++) begin
      @(negedge Clk);
      nChecks++;
      if (tx[0] !== 1'b1 || done[0] !== 1'b0 || busy[0] !== 1'b0) begin
        nFails++;
        $display("FAIL midrst quiet cycle %0d: got tx=%b done=%b busy=%b expected 1 0 0",
                 k, tx[0], done[0], busy[0]);
      end
    end
    pushOne(0, 8'h06);
    @(posedge Clk);
    expectFrame(0, 16'b0000_0010_0000_1100, 10, 1'b0, "midrst_0x06");
    expectEnd(0, "midrst_0x06");
  endtask

  task automatic test_same_cycle_wrap();
    logic [7:0] w [10];
    w = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    fork
      begin
        int idx;
        int guard;
        @(negedge Clk); din[0] = w[0]; en[0] = 1'b1;
        @(posedge Clk);
        @(negedge Clk); din[0] = w[1];
        @(posedge Clk);
        @(negedge Clk); din[0] = w[2];
        @(posedge Clk);
        @(negedge Clk); en[0] = 1'b0;
        // last stop cycle of frame 0 is cycle 39 after the pop edge
        repeat (38) @(negedge Clk);
        nChecks++;
        if (cnt[0] !== 3'd2) begin
          nFails++;
          $display("FAIL samecycle before: got cnt=%0d expected 2", cnt[0]);
        end
        din[0] = w[3];
        en[0]  = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        nChecks++;
        if (cnt[0] !== 3'd2) begin
          nFails++;
          $display("FAIL samecycle push_pop: got cnt=%0d expected 2", cnt[0]);
        end
        idx   = 4;
        guard = 0;
        en[0] = 1'b0;
        while (idx < 10 && guard < 2000) begin
          if (rdy[0]) begin
            din[0] = w[idx];
            en[0]  = 1'b1;
            idx++;
          end else begin
            en[0] = 1'b0;
          end
          @(posedge Clk);
          @(negedge Clk);
          guard++;
        end
        en[0] = 1'b0;
        nChecks++;
        if (idx != 10) begin
          nFails++;
          $display("FAIL samecycle producer timeout: got %0d pushed expected 10", idx);
        end
      end
      begin
        @(negedge Clk);
        @(posedge Clk);
        @(posedge Clk);
        for (int i = 0; i < 10; i++) begin
          expectFrame(0, frame8n1(w[i]), 10, (i != 0), $sformatf("wrap_frame%0d", i));
        end
        expectEnd(0, "wrap");
      end
    join
  endtask

  initial begin
    din[0] = 8'h0;
    din[1] = 8'h0;
    din[2] = 8'h0;
    test_reset();
    test_single_frame();
    test_parity();
    test_seven_data_two_stop();
    test_back_to_back();
    test_reset_mid_frame();
    test_same_cycle_wrap();
    repeat (2) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
